rx_uart: RTL
============

Name: rx_uart

Overview:
- RS-232 style serial receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, idle-high line.
- Oversamples the serial line in the 50 MHz system clock domain and recovers bytes.
- Pushes each good byte into the receive FIFO through a single-cycle write strobe.
- Sits upstream of the FIFO that feeds the transmitter; together they form the UART loop.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bits per second.
- BIT_CLKS, CLK_FREQ/BAUD_RATE (5208): clk cycles per bit, derived.
- HALF_CLKS, BIT_CLKS/2 (2604): clk cycles to the middle of the start bit, derived.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- rxData  input  1  asynchronous serial line, idle high.
- full  input  1  receive FIFO full flag.
- din  output  8  received byte; valid while wrEn=1.
- wrEn  output  1  one-cycle FIFO write strobe.
- frameErr  output  1  one-cycle pulse on a bad stop bit.
- overrun  output  1  one-cycle pulse when a good byte is dropped because full=1.
- busy  output  1  high from start-bit detection until the frame completes.

Behaviour:
- Reset is synchronous and active-high. Outputs after reset:
  - din=0, wrEn=0, frameErr=0, overrun=0, busy=0.
  - Synchronizer flops preset to 1.
  - State = IDLE; bit counter, cycle counter and shift register cleared.
- rxData passes through a 2-flop synchronizer. All decisions use the synchronized value rxS. Synchronizer latency is 2 clk.
- Cycle counter: 13 bits. It saturates nowhere; it is cleared on every state transition and at each sample point.
- IDLE:
  - busy=0.
  - On rxS==0, go to START, clear the counter, set busy=1.
- START:
  - Count to HALF_CLKS-1, then sample rxS.
  - rxS==1: glitch. Return to IDLE with no output.
  - rxS==0: go to DATA with bitIdx=0.
- DATA:
  - Every BIT_CLKS cycles, sample rxS into shift[bitIdx]; data is LSB first.
  - After the 8th sample (bitIdx==7), go to STOP.
  - Without PARITY_EN, go to STOP; with PARITY_EN, go to PARITY first.
- STOP: after BIT_CLKS cycles, sample rxS.
  - rxS==1, full==0: on the next clk, din=shift and wrEn=1 for exactly 1 cycle. Go to IDLE.
  - rxS==1, full==1: overrun=1 for 1 cycle, no write, din unchanged. Go to IDLE.
  - rxS==0: frameErr=1 for 1 cycle, no write. Go to BREAK.
  - full is sampled on the same clk as the stop-bit sample.
- BREAK:
  - Stay here until rxS==1, then go to IDLE.
  - Prevents a held-low line (break) from producing false frames.
- Timing:
  - The IDLE return happens at mid-stop-bit, so the next start edge is caught with half a bit of margin.
  - Back-to-back frames with no idle gap must be received.
  - wrEn latency: 1 clk after the stop-bit sample, about 9.5 bit times after the start edge, plus 2 clk for the synchronizer.
- rst asserted mid-frame:
  - Abort immediately. No wrEn, frameErr or overrun for the partial frame.
  - The synchronizer is re-preset to 1, so a line that is still low after reset is treated as a new start edge once rxS falls.
- din holds its last written value between strobes.
- At most one of wrEn, frameErr and overrun is high in any cycle.

Optional Feature:
- Macro: RX_UART_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP, sampled BIT_CLKS after the last data bit.
  - Even parity is checked over the 8 data bits.
  - Extra output parityErr, 1 bit, reset 0.
  - On a parity mismatch, parityErr pulses for 1 cycle coincident with the stop-bit decision, and there is no write.
  - A parity mismatch takes precedence over overrun.
  - A framing error still pulses frameErr; parityErr may pulse in the same cycle.
- Undefined:
  - No PARITY state and no parityErr port.
  - The frame is exactly 10 bits.

Test Plan:
- Send 0x55 at 9600 baud, full=0 -> exactly one wrEn pulse, 1 clk wide, din=0x55, busy falls the same cycle as wrEn; frameErr=0 and overrun=0.
- Hold rxData low for 1000 clk then high -> return to IDLE, no wrEn, frameErr or overrun; the next 0xA3 frame is received correctly.
- Send 0xA5 with the stop bit driven 0, line low for 3 more bit times -> one frameErr pulse, no wrEn, no further events until the line goes high; then 0x12 is received with din=0x12.
- full=1, send 0x3C -> one overrun pulse, no wrEn, din keeps its previous value. Drop full and send 0x3D -> wrEn with din=0x3D.
- Back-to-back 0x00, 0xFF, 0x81 with zero idle gap -> three wrEn pulses about 10 bit times apart, din=0x00, 0xFF, 0x81 in order.
- Assert rst for 1 clk in the middle of data bit 4 of 0x77, then send 0xC6 -> no event for the aborted frame; wrEn with din=0xC6. With RX_UART_PARITY_EN, send 0x07 with parity bit 0 -> parityErr pulse, no wrEn.

Source files
------------

// File: rtl/rx_uart_if.sv
// Receiver-side bundle for rx_uart: serial line, FIFO write port and status pulses.
// parityErr exists only when RX_UART_PARITY_EN is defined.
interface rx_uart_if;
  logic       rxData;
  logic       full;
  logic [7:0] din;
  logic       wrEn;
  logic       frameErr;
  logic       overrun;
  logic       busy;
`ifdef RX_UART_PARITY_EN
  logic       parityErr;

  modport master (
    input  rxData, full,
    output din, wrEn, frameErr, overrun, busy, parityErr
  );

  modport slave (
    output rxData, full,
    input  din, wrEn, frameErr, overrun, busy, parityErr
  );
`else
  modport master (
    input  rxData, full,
    output din, wrEn, frameErr, overrun, busy
  );

  modport slave (
    output rxData, full,
    input  din, wrEn, frameErr, overrun, busy
  );
`endif
endinterface

// File: rtl/rx_uart.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle FIFO write strobe.
// Define RX_UART_PARITY_EN to add an even-parity bit between data and stop.
module rx_uart #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input logic        clk,
  input logic        rst,
  rx_uart_if.master  bus
);

  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam logic [12:0] BIT_LAST  = 13'(BIT_CLKS - 1);
  localparam logic [12:0] HALF_LAST = 13'(HALF_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
`ifdef RX_UART_PARITY_EN
    ,
    PARITY
`endif
  } state_e;

  state_e      state_q;
  logic        rxMeta_q;
  logic        rxS_q;
  logic [12:0] cnt_q;
  logic [12:0] cnt_d;
  logic [2:0]  bitIdx_q;
  logic [7:0]  shift_q;
  logic [7:0]  din_q;
  logic        wrEn_q;
  logic        frameErr_q;
  logic        overrun_q;
  logic        busy_q;
`ifdef RX_UART_PARITY_EN
  logic        parBit_q;
  logic        parityErr_q;
  logic        parityBad;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign parityBad = ^{shift_q, parBit_q};
  assign bus.parityErr = parityErr_q;
`endif

  assign cnt_d        = cnt_q + 13'd1;
  assign bus.din      = din_q;
  assign bus.wrEn     = wrEn_q;
  assign bus.frameErr = frameErr_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q   <= 1'b1;
      rxS_q      <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      din_q      <= '0;
      wrEn_q     <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RX_UART_PARITY_EN
      parBit_q    <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      rxMeta_q   <= bus.rxData;
      rxS_q      <= rxMeta_q;
      wrEn_q     <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef RX_UART_PARITY_EN
      parityErr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (!rxS_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            if (rxS_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q            <= '0;
            shift_q[bitIdx_q] <= rxS_q;
            if (bitIdx_q == 3'd7) begin
`ifdef RX_UART_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef RX_UART_PARITY_EN
        PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= '0;
            parBit_q <= rxS_q;
            state_q  <= STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        // Decision at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            if (rxS_q) begin
              state_q <= IDLE;
`ifdef RX_UART_PARITY_EN
              if (parityBad) begin
                parityErr_q <= 1'b1;
              end else
`endif
              if (bus.full) begin
                overrun_q <= 1'b1;
              end else begin
                wrEn_q <= 1'b1;
                din_q  <= shift_q;
              end
            end else begin
              frameErr_q <= 1'b1;
`ifdef RX_UART_PARITY_EN
              parityErr_q <= parityBad;
`endif
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        BREAK: begin
          if (rxS_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
